// File: rtl/bp_bht_update_sched.sv
// bp_bht_update_sched: in-order resolution queue that schedules BHT updates.
// Predictions enter through a one-entry capture stage and retire from the head on resolve.
module bp_bht_update_sched #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       pred_v_i,
    input  logic [PC_W-1:0]            pred_pc_i,
    output logic                       pred_ready_o,
    output logic [PC_W-1:0]            bht_r_pc_o,
    input  logic                       predict_i,
    input  logic                       res_v_i,
    input  logic                       res_taken_i,
    input  logic                       flush_i,
    output logic                       bht_w_o,
    output logic [PC_W-1:0]            bht_w_pc_o,
    output logic                       correct_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [CNT_W-1:0]           mispred_cnt_o,
    output logic                       err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]  mem_pc_q [DEPTH];
    logic [DEPTH-1:0] mem_pred_q;
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    qcnt_q, qcnt_d;
    logic             cap_v_q;
    logic [PC_W-1:0]  cap_pc_q;
    logic             bht_w_q, correct_q, err_q;
    logic [PC_W-1:0]  bht_w_pc_q;
    logic [CNT_W-1:0] mis_q;
    logic             accept, push, pop, err_d, hit_d;

    assign count_o      = qcnt_q + CW'(cap_v_q);
    assign pred_ready_o = ~flush_i & (count_o < CW'(DEPTH));
    assign bht_r_pc_o   = pred_pc_i;
    assign accept       = pred_v_i & pred_ready_o;
    // the capture-stage entry is never resolvable; only committed entries can pop
    assign push         = cap_v_q & ~flush_i;
    assign pop          = res_v_i & ~flush_i & (qcnt_q != '0);
    assign err_d        = res_v_i & ~flush_i & (qcnt_q == '0);
    assign hit_d        = mem_pred_q[rd_q] == res_taken_i;
    assign qcnt_d       = qcnt_q + CW'(push) - CW'(pop);

    assign bht_w_o       = bht_w_q;
    assign bht_w_pc_o    = bht_w_pc_q;
    assign correct_o     = correct_q;
    assign mispred_cnt_o = mis_q;
    assign err_o         = err_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc_q[wr_q]   <= cap_pc_q;
            mem_pred_q[wr_q] <= predict_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q       <= '0;
            rd_q       <= '0;
            qcnt_q     <= '0;
            cap_v_q    <= 1'b0;
            cap_pc_q   <= '0;
            bht_w_q    <= 1'b0;
            bht_w_pc_q <= '0;
            correct_q  <= 1'b0;
            err_q      <= 1'b0;
            mis_q      <= '0;
        end else begin
            cap_v_q <= accept;
            if (accept) cap_pc_q <= pred_pc_i;
            wr_q   <= flush_i ? '0 : wr_q + AW'(push);
            rd_q   <= flush_i ? '0 : rd_q + AW'(pop);
            qcnt_q <= flush_i ? '0 : qcnt_d;
            bht_w_q <= pop;
            err_q   <= err_d;
            if (pop) begin
                bht_w_pc_q <= mem_pc_q[rd_q];
                correct_q  <= hit_d;
            end
            if (pop && !hit_d && !(&mis_q)) mis_q <= mis_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_bp_bht_update_sched.sv
// tb_bp_bht_update_sched: vector table plus queue-based reference model and write scoreboard.
module tb_bp_bht_update_sched;
    logic        clk_i = 0, reset_i = 1;
    logic        pred_v_i = 0, predict_i = 0, res_v_i = 0, res_taken_i = 0, flush_i = 0;
    logic [31:0] pred_pc_i = 0;
    logic        pred_ready_o, bht_w_o, correct_o, err_o;
    logic [31:0] bht_r_pc_o, bht_w_pc_o;
    logic [3:0]  count_o;
    logic [1:0]  mispred_cnt_o;

    bp_bht_update_sched #(.PC_W(32), .DEPTH(8), .CNT_W(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .pred_v_i(pred_v_i), .pred_pc_i(pred_pc_i),
        .pred_ready_o(pred_ready_o), .bht_r_pc_o(bht_r_pc_o), .predict_i(predict_i),
        .res_v_i(res_v_i), .res_taken_i(res_taken_i), .flush_i(flush_i), .bht_w_o(bht_w_o),
        .bht_w_pc_o(bht_w_pc_o), .correct_o(correct_o), .count_o(count_o),
        .mispred_cnt_o(mispred_cnt_o), .err_o(err_o));

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic [31:0] pc; logic pred; } ent_t;
    typedef struct packed { logic [31:0] pc; logic c; } wr_t;
    typedef struct packed {
        logic pv; logic [31:0] pc; logic pr; logic rv; logic rt; logic fl;
        logic ew; logic [31:0] ewpc; logic ec; logic [3:0] ecnt; logic [1:0] emis;
    } vec_t;

    ent_t        mq[$];
    wr_t         sb[$];
    bit          m_cap_v;
    logic [31:0] m_cap_pc;
    int          m_mis;
    int          errors = 0, checks = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete(); sb.delete(); m_cap_v = 0; m_mis = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, pred_ready_o, 1);
        chk({tag, "_w"}, bht_w_o, 0);
        chk({tag, "_wpc"}, bht_w_pc_o, 0);
        chk({tag, "_corr"}, correct_o, 0);
        chk({tag, "_cnt"}, count_o, 0);
        chk({tag, "_mis"}, mispred_cnt_o, 0);
        chk({tag, "_err"}, err_o, 0);
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
    task automatic cyc(input bit pv, input logic [31:0] pc, input bit pr, input bit rv, input bit rt, input bit fl);
        bit rdy, pop, err;
        ent_t e;
        wr_t w;
        pred_v_i = pv; pred_pc_i = pc; predict_i = pr; res_v_i = rv; res_taken_i = rt; flush_i = fl;
        #1;
        rdy = !fl && (mq.size() + int'(m_cap_v) < 8);
        chk("ready", pred_ready_o, rdy);
        chk("count", count_o, mq.size() + int'(m_cap_v));
        chk("rd_pc", bht_r_pc_o, pc);
        pop = rv && !fl && mq.size() > 0;
        err = rv && !fl && mq.size() == 0;
        if (pop) begin
            e = mq.pop_front();
            sb.push_back({e.pc, e.pred == rt});
            if (e.pred != rt && m_mis != 3) m_mis++;
        end
        if (m_cap_v && !fl) mq.push_back({m_cap_pc, pr});
        if (fl) begin
            mq.delete(); m_cap_v = 0;
        end else begin
            m_cap_v = pv && rdy; m_cap_pc = pc;
        end
        @(posedge clk_i); #1;
        chk("bht_w", bht_w_o, pop);
        chk("err", err_o, err);
        chk("mispred", mispred_cnt_o, m_mis);
        if (bht_w_o || pop) begin
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else begin
                w = sb.pop_front();
                chk("wpc", bht_w_pc_o, w.pc);
                chk("correct", correct_o, w.c);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 24 && (mq.size() > 0 || m_cap_v); i++)
            cyc(0, 0, $urandom_range(1), mq.size() > 0, $urandom_range(1), 0);
    endtask

    vec_t tv[5];

    initial begin
        tv[0] = '{1, 32'h100, 0, 0, 0, 0, 0, 32'h0,   0, 4'd1, 2'd0};
        tv[1] = '{1, 32'h104, 1, 0, 0, 0, 0, 32'h0,   0, 4'd2, 2'd0};
        tv[2] = '{0, 32'h0,   0, 1, 1, 0, 1, 32'h100, 1, 4'd1, 2'd0};
        tv[3] = '{0, 32'h0,   0, 1, 1, 0, 1, 32'h104, 0, 4'd0, 2'd1};
        tv[4] = '{0, 32'h0,   0, 0, 0, 0, 0, 32'h104, 0, 4'd0, 2'd1};
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("rst");
        reset_i = 0;

        // 1: two predictions, one correct and one mispredicted
        for (int i = 0; i < 5; i++) begin
            cyc(tv[i].pv, tv[i].pc, tv[i].pr, tv[i].rv, tv[i].rt, tv[i].fl);
            chk("t1_w", bht_w_o, tv[i].ew);
            chk("t1_wpc", bht_w_pc_o, tv[i].ewpc);
            chk("t1_corr", correct_o, tv[i].ec);
            chk("t1_cnt", count_o, tv[i].ecnt);
            chk("t1_mis", mispred_cnt_o, tv[i].emis);
        end

        // 2: fill to DEPTH, then free one slot and overlap push with pop
        for (int i = 0; i < 8; i++) cyc(1, 32'h200 + 4 * i, $urandom_range(1), 0, 0, 0);
        #1;
        chk("full_cnt", count_o, 8);
        chk("full_ready", pred_ready_o, 0);
        cyc(1, 32'h2f0, 1, 1, 1, 0);
        chk("after_pop_ready", pred_ready_o, 1);
        cyc(1, 32'h300, 0, 1, 0, 0);
        cyc(1, 32'h304, 1, 1, 1, 0);
        chk("pushpop_cnt", count_o, 7);
        drain();

        // 3: resolve with empty queue, then resolve while only the capture stage is valid
        cyc(0, 0, 0, 1, 1, 0);
        cyc(1, 32'h500, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        drain();

        // 4: flush with resolve and request asserted, a write from the prior cycle in flight
        for (int i = 0; i < 5; i++) cyc(1, 32'h600 + 4 * i, $urandom_range(1), 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(1, 32'h700, 1, 1, 1, 1);
        chk("flush_cnt", count_o, 0);
        cyc(1, 32'h800, 0, 0, 0, 0);
        cyc(1, 32'h804, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        drain();

        // 5: 3*DEPTH entries streamed through to exercise pointer wrap
        for (int i = 0; i < 30; i++)
            cyc(i < 24, 32'h1000 + 4 * i, $urandom_range(1), mq.size() > 0, $urandom_range(1), 0);
        drain();

        // 6: saturate the mispredict counter, then reset mid-stream
        for (int i = 0; i < 4; i++) cyc(1, 32'h2000 + 4 * i, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 0);
        chk("mis_sat", mispred_cnt_o, 3);
        for (int i = 0; i < 3; i++) cyc(1, 32'h3000 + 4 * i, 1, i == 2, 1, 0);
        pred_v_i = 0; res_v_i = 0; flush_i = 0;
        reset_i = 1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk_i); #1;
        reset_i = 0;
        model_reset();
        cyc(1, 32'h4000, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
